chip_controller: RTL and testbench
==================================

# chip_controller

Top-level run sequencer for the chip. Consumes the single-cycle `start_flag` pulse produced by the start-pin rising-edge detector, then sequences the datapath through one load phase and `num_blocks` process phases using valid/ready and done handshakes. It reports `busy`, a one-cycle `done` pulse and a sticky `error` (zero-length job or datapath timeout). It sits between the edge detector and the datapath, and is the only block allowed to drive datapath enables.

## Interface
Parameters:
- CNT_WIDTH, 8, width of `num_blocks` and `block_count`
- TIMEOUT, 255, max cycles spent in WAIT for `proc_done` before error; must be ≥2

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- n_rst  in  1  reset; asynchronous, active-low
- start_flag  in  1  one-cycle start pulse from the edge detector
- abort  in  1  synchronous abort request, level
- num_blocks  in  CNT_WIDTH  job length; sampled only on an accepted start
- load_done  in  1  datapath finished loading configuration
- proc_ready  in  1  datapath can accept a process request
- proc_done  in  1  one-cycle pulse: current block finished
- busy  out  1  high in any state except IDLE and ERR
- load_en  out  1  high throughout LOAD
- proc_start  out  1  process request (valid), held high throughout ISSUE
- block_count  out  CNT_WIDTH  blocks completed in the current job
- done  out  1  one-cycle pulse on job completion
- error  out  1  sticky error indication

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, DONE, ERR. All outputs are Moore-decoded from registered state/counters; there are no combinational input-to-output paths.
- IDLE: `start_flag`=1 and `num_blocks`=0 -> ERR. `start_flag`=1 and `num_blocks`≠0 -> latch `num_blocks` into `total`, clear `block_count`, go to LOAD.
- LOAD: `load_en`=1. `load_done`=1 -> ISSUE.
- ISSUE: `proc_start`=1. Handshake occurs when `proc_ready`=1 in the same cycle -> WAIT, timer cleared to 0.
- WAIT: timer increments each cycle.
  - `proc_done`=1 -> `block_count`+1. If the new count equals `total` -> DONE, else -> ISSUE.
  - Timer reaching TIMEOUT-1 without `proc_done` -> ERR.
  - `proc_done` takes priority over timeout when both occur in the same cycle.
- DONE: `done`=1 for exactly one cycle, then IDLE. `block_count` holds its final value until the next accepted start.
- ERR: `error`=1; `busy`=0. `start_flag` is handled exactly as in IDLE (the error clears on leaving ERR). Nothing else leaves ERR.
- `abort`=1 in LOAD/ISSUE/WAIT -> IDLE next cycle. No `done`, no `error`; `block_count` holds its value. In IDLE/DONE/ERR, `abort` is ignored.
- `start_flag` is ignored while `busy`=1; there is no queuing.
- `proc_done` outside WAIT is ignored. Counter arithmetic is CNT_WIDTH-bit unsigned; it never wraps because `total` ≤ 2^CNT_WIDTH−1.

## Timing
- Reset (n_rst=0, asynchronous): state=IDLE, timer=0, total=0, `block_count`=0. All 1-bit outputs are 0.
- `start_flag` sampled at edge k -> `busy`=1 and `load_en`=1 in the cycle after edge k. Latency: 1 cycle.
- `load_done` at edge k -> `proc_start`=1 after edge k.
- Handshake at edge k -> `proc_start`=0 after edge k.
- Last `proc_done` at edge k -> `done`=1 in the cycle after edge k. `busy` stays 1 during the DONE cycle and is 0 one cycle later.
- Minimum job duration for N blocks, with the datapath always ready and done arriving on the first WAIT cycle: 1 + 2N + 1 cycles from start to IDLE.
- Timeout: the ERR transition happens TIMEOUT cycles after entering WAIT.

## Structure
- Package `chip_ctrl_pkg` holds:
  - `state_t` enum (3-bit encoding)
  - default CNT_WIDTH and TIMEOUT constants
- Sub-module `flex_counter` serves as the WAIT timeout timer. It has clear and count-enable inputs and a rollover flag at TIMEOUT-1.
- `block_count` and `total` are registers inside `chip_controller`.

## Test plan
- Reset mid-WAIT (n_rst low between edges) -> all outputs 0 immediately, without waiting for a clock edge; state IDLE.
- num_blocks=3, `proc_ready` and `load_done` tied 1, `proc_done` on each first WAIT cycle -> `done` pulses at cycle 8 after start, `block_count`=3, `busy` low at cycle 9.
- num_blocks=0 with start -> `error`=1 next cycle, `busy` stays 0. A second start with num_blocks=2 clears `error` and runs normally.
- TIMEOUT=10, `proc_done` never arrives -> ERR exactly 10 cycles after entering WAIT, `error`=1. Repeat with `proc_done` on the 10th cycle -> no error.
- `proc_ready` held low 5 cycles in ISSUE -> `proc_start` held high all 5 cycles, then drops one cycle after `proc_ready` rises.
- `abort` during block 2 of 4 -> IDLE next cycle, `block_count`=1, no `done`/`error`. A `start_flag` while `busy` is ignored.

Source files
------------

// File: rtl/chip_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chip_ctrl_pkg
// Description : Shared types and default constants for the chip run
//               sequencer (state encoding, counter width, WAIT timeout).
// Revision    : 1.0 - initial release
// ============================================================================
package chip_ctrl_pkg;

   // Default width of the job length / completed-block counters.
   localparam int DEF_CNT_WIDTH = 8;

   // Default number of WAIT cycles tolerated before a datapath timeout.
   localparam int DEF_TIMEOUT = 255;

   // Sequencer states, explicit 3-bit encoding.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

endpackage : chip_ctrl_pkg
`default_nettype wire

// File: rtl/chip_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : chip_controller_if
// Description : Start/abort request, datapath handshake and status bundle
//               between the run sequencer (master) and its surroundings
//               (slave: edge detector, datapath and status consumers).
// Revision    : 1.0 - initial release
// ============================================================================
interface chip_controller_if
   import chip_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

   // Requests into the sequencer
   logic                 start_flag;
   logic                 abort;
   logic [CNT_WIDTH-1:0] num_blocks;

   // Datapath status into the sequencer
   logic                 load_done;
   logic                 proc_ready;
   logic                 proc_done;

   // Sequencer outputs
   logic                 busy;
   logic                 load_en;
   logic                 proc_start;
   logic [CNT_WIDTH-1:0] block_count;
   logic                 done;
   logic                 error;

   // Sequencer side
   modport master (
      input  start_flag,
      input  abort,
      input  num_blocks,
      input  load_done,
      input  proc_ready,
      input  proc_done,
      output busy,
      output load_en,
      output proc_start,
      output block_count,
      output done,
      output error
   );

   // Environment side
   modport slave (
      output start_flag,
      output abort,
      output num_blocks,
      output load_done,
      output proc_ready,
      output proc_done,
      input  busy,
      input  load_en,
      input  proc_start,
      input  block_count,
      input  done,
      input  error
   );

endinterface : chip_controller_if
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// Module      : flex_counter
// Description : Up-counter with synchronous clear and count enable. The
//               rollover flag is decoded from the registered count and is
//               high while the count sits at TIMEOUT-1; the next enabled
//               cycle wraps the count back to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module flex_counter
   import chip_ctrl_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int WIDTH   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
)(
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             count_en,
   output logic [WIDTH-1:0] count,
   output logic             rollover
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT - 1);

   // Flag is purely a decode of the stored count, so it carries no
   // combinational path from clear/count_en.
   assign rollover = (count == LAST);

   // Count register: clear dominates, then enabled increment with wrap.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en) begin
         if (rollover) begin
            count <= '0;
         end else begin
            count <= count + WIDTH'(1);
         end
      end
   end

endmodule : flex_counter
`default_nettype wire

// File: rtl/chip_controller.sv
`default_nettype none
// ============================================================================
// Module      : chip_controller
// Description : Top-level run sequencer. Accepts a one-cycle start pulse,
//               drives the datapath through one LOAD phase and num_blocks
//               ISSUE/WAIT process phases, and reports busy, a one-cycle
//               done pulse and a sticky error (zero-length job or WAIT
//               timeout). All outputs decode registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
module chip_controller
   import chip_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH,
   parameter int TIMEOUT   = DEF_TIMEOUT
)(
   input  logic               clk,
   input  logic               n_rst,
   chip_controller_if.master  bus
);

   localparam int TMR_WIDTH = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t               state;
   state_t               state_next;
   logic [CNT_WIDTH-1:0] total;
   logic [CNT_WIDTH-1:0] total_next;
   logic [CNT_WIDTH-1:0] block_count;
   logic [CNT_WIDTH-1:0] count_next;
   logic [CNT_WIDTH-1:0] count_inc;

   logic                 tmr_clear;
   logic                 tmr_en;
   logic [TMR_WIDTH-1:0] tmr_count;
   logic                 tmr_rollover;

   // The timer only runs while waiting on the datapath; every other state
   // holds it at zero, so it always starts WAIT from a clean count.
   assign tmr_clear = (state != WAIT);
   assign tmr_en    = (state == WAIT);

   flex_counter #(
      .TIMEOUT (TIMEOUT),
      .WIDTH   (TMR_WIDTH)
   ) u_timer (
      .clk      (clk),
      .n_rst    (n_rst),
      .clear    (tmr_clear),
      .count_en (tmr_en),
      .count    (tmr_count),
      .rollover (tmr_rollover)
   );

   // Count cannot wrap: total is at most 2^CNT_WIDTH-1 and the job ends
   // when the incremented value reaches it.
   assign count_inc = block_count + CNT_WIDTH'(1);

   // State, job length and completed-block registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         total       <= '0;
         block_count <= '0;
      end else begin
         state       <= state_next;
         total       <= total_next;
         block_count <= count_next;
      end
   end

   // Next-state, job-length latch and block-count update.
   always_comb begin
      state_next = state;
      total_next = total;
      count_next = block_count;

      case (state)
         // IDLE and ERR treat a start identically; a zero-length job is
         // an error, anything else is latched and starts the load phase.
         IDLE, ERR: begin
            if (bus.start_flag) begin
               if (bus.num_blocks == '0) begin
                  state_next = ERR;
               end else begin
                  state_next = LOAD;
                  total_next = bus.num_blocks;
                  count_next = '0;
               end
            end
         end

         LOAD: begin
            if (bus.abort) begin
               state_next = IDLE;
            end else if (bus.load_done) begin
               state_next = ISSUE;
            end
         end

         ISSUE: begin
            if (bus.abort) begin
               state_next = IDLE;
            end else if (bus.proc_ready) begin
               state_next = WAIT;
            end
         end

         // A completion in the last timer cycle still counts as success.
         WAIT: begin
            if (bus.abort) begin
               state_next = IDLE;
            end else if (bus.proc_done) begin
               count_next = count_inc;
               state_next = (count_inc == total) ? DONE : ISSUE;
            end else if (tmr_rollover) begin
               state_next = ERR;
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Moore output decode.
   assign bus.busy        = (state != IDLE) && (state != ERR);
   assign bus.load_en     = (state == LOAD);
   assign bus.proc_start  = (state == ISSUE);
   assign bus.done        = (state == DONE);
   assign bus.error       = (state == ERR);
   assign bus.block_count = block_count;

endmodule : chip_controller
`default_nettype wire

// File: tb/tb_chip_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_chip_controller
// Description : Directed, table-driven bench for chip_controller with
//               hand-written sequences for timeout, abort and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chip_controller;

   localparam int CW = 8;
   localparam int TO = 10;

   typedef struct packed {
      logic          sf;
      logic          ab;
      logic [CW-1:0] nb;
      logic          ld;
      logic          pr;
      logic          pd;
      logic          busy;
      logic          le;
      logic          ps;
      logic [CW-1:0] bc;
      logic          dn;
      logic          er;
   } vec_t;

   logic clk   = 1'b0;
   logic n_rst = 1'b1;

   int n_vec = 0;
   int n_bad = 0;

   vec_t tbl [25];

   chip_controller_if #(.CNT_WIDTH(CW)) bus ();

   chip_controller #(
      .CNT_WIDTH (CW),
      .TIMEOUT   (TO)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   function automatic vec_t mk(input int sf, input int ab, input int nb,
                               input int ld, input int pr, input int pd,
                               input int b,  input int le, input int ps,
                               input int bc, input int dn, input int er);
      vec_t r;
      r.sf = sf[0]; r.ab = ab[0]; r.nb = nb[CW-1:0];
      r.ld = ld[0]; r.pr = pr[0]; r.pd = pd[0];
      r.busy = b[0]; r.le = le[0]; r.ps = ps[0];
      r.bc = bc[CW-1:0]; r.dn = dn[0]; r.er = er[0];
      return r;
   endfunction

   task automatic drive(input logic sf, input logic ab, input logic [CW-1:0] nb,
                        input logic ld, input logic pr, input logic pd);
      bus.start_flag = sf;
      bus.abort      = ab;
      bus.num_blocks = nb;
      bus.load_done  = ld;
      bus.proc_ready = pr;
      bus.proc_done  = pd;
   endtask

   task automatic check(input string name, input logic b, input logic le,
                        input logic ps, input logic [CW-1:0] bc,
                        input logic dn, input logic er);
      logic [CW+4:0] act;
      logic [CW+4:0] exp;
      act = {bus.busy, bus.load_en, bus.proc_start, bus.block_count, bus.done, bus.error};
      exp = {b, le, ps, bc, dn, er};
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got busy=%b load_en=%b proc_start=%b block_count=%0d done=%b error=%b, expected busy=%b load_en=%b proc_start=%b block_count=%0d done=%b error=%b",
                  name, bus.busy, bus.load_en, bus.proc_start, bus.block_count, bus.done, bus.error,
                  b, le, ps, bc, dn, er);
      end
   endtask

   // One rising edge, then compare the registered outputs 1 ns later.
   task automatic tick(input string name, input logic b, input logic le,
                       input logic ps, input logic [CW-1:0] bc,
                       input logic dn, input logic er);
      @(posedge clk);
      #1;
      check(name, b, le, ps, bc, dn, er);
   endtask

   // Run-time ceiling.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      //                 sf ab nb ld pr pd | bsy le ps bc dn er
      tbl[0]  = mk(1, 0, 3, 1, 1, 0,   1, 1, 0, 0, 0, 0); // start N=3 -> LOAD
      tbl[1]  = mk(0, 0, 0, 1, 1, 0,   1, 0, 1, 0, 0, 0); // -> ISSUE
      tbl[2]  = mk(0, 0, 0, 1, 1, 0,   1, 0, 0, 0, 0, 0); // -> WAIT
      tbl[3]  = mk(0, 0, 0, 1, 1, 1,   1, 0, 1, 1, 0, 0); // blk1 -> ISSUE
      tbl[4]  = mk(0, 0, 0, 1, 1, 0,   1, 0, 0, 1, 0, 0);
      tbl[5]  = mk(0, 0, 0, 1, 1, 1,   1, 0, 1, 2, 0, 0); // blk2
      tbl[6]  = mk(0, 0, 0, 1, 1, 0,   1, 0, 0, 2, 0, 0);
      tbl[7]  = mk(0, 0, 0, 1, 1, 1,   1, 0, 0, 3, 1, 0); // blk3 -> DONE (cycle 8)
      tbl[8]  = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 3, 0, 0); // IDLE (cycle 9)
      tbl[9]  = mk(0, 1, 0, 0, 0, 1,   0, 0, 0, 3, 0, 0); // abort/done ignored in IDLE
      tbl[10] = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 3, 0, 1); // zero-length -> ERR
      tbl[11] = mk(0, 1, 0, 0, 0, 1,   0, 0, 0, 3, 0, 1); // ERR sticky, abort ignored
      tbl[12] = mk(1, 0, 2, 0, 0, 0,   1, 1, 0, 0, 0, 0); // restart N=2 clears error
      tbl[13] = mk(1, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0); // start while busy ignored
      tbl[14] = mk(0, 0, 0, 1, 0, 0,   1, 0, 1, 0, 0, 0); // -> ISSUE
      tbl[15] = mk(1, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0); // ready low 1 (start ignored)
      tbl[16] = mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0); // ready low 2
      tbl[17] = mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0); // ready low 3
      tbl[18] = mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0); // ready low 4
      tbl[19] = mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0); // ready low 5
      tbl[20] = mk(0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0); // handshake -> WAIT
      tbl[21] = mk(0, 0, 0, 0, 1, 1,   1, 0, 1, 1, 0, 0);
      tbl[22] = mk(0, 0, 0, 0, 1, 0,   1, 0, 0, 1, 0, 0);
      tbl[23] = mk(0, 0, 0, 0, 1, 1,   1, 0, 0, 2, 1, 0); // -> DONE
      tbl[24] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0, 0); // -> IDLE

      // Reset state
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      #1 n_rst = 1'b0;
      #1 check("reset", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      n_rst = 1'b1;

      // Table-driven main flow
      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].sf, tbl[i].ab, tbl[i].nb, tbl[i].ld, tbl[i].pr, tbl[i].pd);
         tick($sformatf("vec%0d", i), tbl[i].busy, tbl[i].le, tbl[i].ps,
              tbl[i].bc, tbl[i].dn, tbl[i].er);
      end

      // Timeout: no proc_done, ERR on the TO-th edge after entering WAIT
      drive(1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0);
      tick("to_load", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      tick("to_issue", 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
      tick("to_wait", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      for (int i = 1; i < TO; i++)
         tick($sformatf("to_wait%0d", i), 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      tick("to_err", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

      // proc_done on the last WAIT cycle wins over the timeout
      drive(1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0);
      tick("tl_load", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      tick("tl_issue", 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
      tick("tl_wait", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      for (int i = 1; i < TO; i++)
         tick($sformatf("tl_wait%0d", i), 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
      tick("tl_done", 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      tick("tl_idle", 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);

      // Abort during block 2 of 4
      drive(1'b1, 1'b0, 8'd4, 1'b1, 1'b1, 1'b0);
      tick("ab_load", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      tick("ab_issue", 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
      tick("ab_wait", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
      tick("ab_blk1", 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      tick("ab_wait2", 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
      tick("ab_idle", 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      tick("ab_quiet", 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);

      // Asynchronous reset in the middle of WAIT
      drive(1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0);
      tick("rs_load", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      tick("rs_issue", 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
      tick("rs_wait", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
      tick("rs_blk1", 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      tick("rs_wait2", 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
      #2 n_rst = 1'b0;
      #1 check("rs_async", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      @(negedge clk);
      n_rst = 1'b1;
      drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      tick("rs_idle", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_chip_controller
`default_nettype wire
